// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave
// Description : I2C target endpoint. Oversamples SCL/SDA on the system clock,
//               detects START/STOP, matches a fixed 7-bit address, returns
//               written bytes to the fabric and sources read bytes from it.
//               SDA is an open-drain request (sda_oe=1 pulls low). No clock
//               stretching; SCL is observed only.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         CLK_FREQ   = 100_000_000,
    parameter int         I2C_FREQ   = 400_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       busy
);

    // Oversampling needs enough system clocks per SCL phase to see both edges.
    if (CLK_FREQ < 20 * I2C_FREQ) begin : g_freq_check
        $error("i2c_slave: CLK_FREQ must be at least 20x I2C_FREQ");
    end

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_WRITE_ACK = 3'd4;
    localparam logic [2:0] S_READ      = 3'd5;
    localparam logic [2:0] S_READ_ACK  = 3'd6;
    localparam logic [2:0] S_IGNORE    = 3'd7;

    // General call (address 0) is never acknowledged.
    localparam logic c_addr_valid = (SLAVE_ADDR != 7'h00);

    logic       r_scl_s1, r_scl_s2, r_scl_h;
    logic       r_sda_s1, r_sda_s2, r_sda_h;
    logic [2:0] r_state;
    logic [2:0] r_bit_cnt;
    // Seven bits suffice: the eighth bit is always taken straight from the bus
    // (receive) or straight from tx_data (transmit MSB).
    logic [6:0] r_shift;
    logic       r_rw;
    logic       r_ack_on;
    logic       r_sda_oe;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_load;

    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl_rise = r_scl_s2 & ~r_scl_h;
    assign w_scl_fall = ~r_scl_s2 & r_scl_h;
    assign w_start    = r_scl_s2 & r_sda_h & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & ~r_sda_h & r_sda_s2;

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_load  = r_tx_load;
    assign busy     = (r_state != S_IDLE);

    // Two-flop synchronisers plus one history flop per pin; idle bus is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_scl_s1, r_scl_s2, r_scl_h} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_h} <= 3'b111;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_scl_h  <= r_scl_s2;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_h  <= r_sda_s2;
        end
    end

    // Protocol state machine; START/STOP override any SCL edge in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_rw       <= 1'b0;
            r_ack_on   <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_load  <= 1'b0;
            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= 3'd0;
                r_ack_on  <= 1'b0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 3'd0;
                r_ack_on  <= 1'b0;
                r_sda_oe  <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[5:0], r_sda_s2};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_rw     <= r_sda_s2;
                                r_ack_on <= 1'b0;
                                if (c_addr_valid && (r_shift == SLAVE_ADDR)) begin
                                    r_state <= S_ADDR_ACK;
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                r_sda_oe <= 1'b1;
                                r_ack_on <= 1'b1;
                            end else begin
                                r_ack_on  <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                if (r_rw) begin
                                    r_shift   <= tx_data[6:0];
                                    r_tx_load <= 1'b1;
                                    r_sda_oe  <= ~tx_data[7];
                                    r_state   <= S_READ;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= S_WRITE;
                                end
                            end
                        end
                    end
                    S_WRITE: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[5:0], r_sda_s2};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_rx_data  <= {r_shift, r_sda_s2};
                                r_rx_valid <= 1'b1;
                                r_ack_on   <= 1'b0;
                                r_state    <= S_WRITE_ACK;
                            end
                        end
                    end
                    S_WRITE_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                r_sda_oe <= 1'b1;
                                r_ack_on <= 1'b1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_ack_on <= 1'b0;
                                r_state  <= S_WRITE;
                            end
                        end
                    end
                    S_READ: begin
                        // bit_cnt wraps to 0 on the 8th rise, marking the last fall.
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end else if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd0) begin
                                r_sda_oe <= 1'b0;
                                r_ack_on <= 1'b0;
                                r_state  <= S_READ_ACK;
                            end else begin
                                r_sda_oe <= ~r_shift[6];
                                r_shift  <= {r_shift[5:0], 1'b0};
                            end
                        end
                    end
                    S_READ_ACK: begin
                        if (w_scl_rise) begin
                            if (r_sda_s2) begin
                                r_state <= S_IGNORE;
                            end else begin
                                r_ack_on <= 1'b1;
                            end
                        end else if (w_scl_fall && r_ack_on) begin
                            r_ack_on  <= 1'b0;
                            r_bit_cnt <= 3'd0;
                            r_shift   <= tx_data[6:0];
                            r_tx_load <= 1'b1;
                            r_sda_oe  <= ~tx_data[7];
                            r_state   <= S_READ;
                        end
                    end
                    S_IDLE, S_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave
// Description : Self-checking bench for i2c_slave. A bus-level master model
//               drives SCL/SDA over a wired-AND SDA line; expectations come
//               from the addressing/transfer rules of the target.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

    localparam int Q = 10;  // quarter SCL period in system clocks

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, rx_valid, tx_load, busy, sda_bus;
    logic [7:0] rx_data;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h42), .CLK_FREQ(100_000_000), .I2C_FREQ(400_000)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_load(tx_load), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_rx = 0;
    int n_tx = 0;
    int viol = 0;
    logic [7:0] rxq[$];
    logic [7:0] last_rx = 8'h00;
    logic prev_rxv = 1'b0, prev_txl = 1'b0, prev_oe = 1'b0;

    typedef struct {
        logic [7:0]  addr;
        int          n;
        logic [23:0] data;
        logic        exp_ack;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse/ordering observer on the falling clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                n_rx++;
                rxq.push_back(rx_data);
            end
            if (tx_load) n_tx++;
            if (rx_valid && tx_load) viol++;
            if (rx_valid && prev_rxv) viol++;
            if (tx_load && prev_txl) viol++;
            if (sda_oe && !prev_oe && scl_m) viol++;
        end
        prev_rxv = rx_valid;
        prev_txl = tx_load;
        prev_oe  = sda_oe;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        if (!scl_m) begin
            sda_m = 1'b1; tick(Q);
            scl_m = 1'b1; tick(Q);
        end
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(Q);
        s = sda_bus;  tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        tx_data = next_tx;
        bus_bit(mack ? 1'b0 : 1'b1, s);
    endtask

    // Reference rule: only the configured, non-zero address is acknowledged.
    function automatic logic model_ack(input logic [7:0] a);
        return (a[7:1] == 7'h42) && (a[7:1] != 7'h00);
    endfunction

    task automatic run_txn(input logic [7:0] addr, input int n, input logic [23:0] data,
                           input logic exp_ack, input string tag);
        int rx0, tx0;
        logic ack;
        logic [7:0] d;
        rx0 = n_rx;
        tx0 = n_tx;
        rxq.delete();
        if (addr[0]) tx_data = data[7:0];
        bus_start();
        write_byte(addr, ack);
        check({tag, " addr_ack"}, 32'(ack), 32'(exp_ack));
        check({tag, " busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (!addr[0]) begin
                write_byte(data[8*i +: 8], ack);
                check($sformatf("%s data_ack%0d", tag, i), 32'(ack), 32'(exp_ack));
            end else begin
                read_byte(i != n - 1, (i < 2) ? data[8*(i+1) +: 8] : 8'h00, d);
                check($sformatf("%s rd%0d", tag, i), 32'(d), exp_ack ? 32'(data[8*i +: 8]) : 32'hFF);
            end
        end
        bus_stop();
        tick(4);
        check({tag, " busy_after_stop"}, 32'(busy), 32'd0);
        check({tag, " rx_valid_count"}, 32'(n_rx - rx0), (exp_ack && !addr[0]) ? 32'(n) : 32'd0);
        check({tag, " tx_load_count"}, 32'(n_tx - tx0), (exp_ack && addr[0]) ? 32'(n) : 32'd0);
        if (exp_ack && !addr[0]) begin
            for (int i = 0; i < n; i++) begin
                if (i < rxq.size())
                    check($sformatf("%s rx_data%0d", tag, i), 32'(rxq[i]), 32'(data[8*i +: 8]));
            end
            last_rx = data[8*(n-1) +: 8];
        end
    endtask

    initial begin
        logic ack, s;
        logic [7:0] d;
        int rx0, tx0;

        tbl[0] = '{8'h84, 1, 24'h0000A5, 1'b1};
        tbl[1] = '{8'h86, 1, 24'h000011, 1'b0};
        tbl[2] = '{8'h85, 2, 24'h00C33C, 1'b1};
        tbl[3] = '{8'h00, 1, 24'h000055, 1'b0};
        tbl[4] = '{8'h84, 3, 24'h7E0080, 1'b1};
        tbl[5] = '{8'h87, 2, 24'h00AA55, 1'b0};
        tbl[6] = '{8'hC4, 1, 24'h000042, 1'b0};

        tick(5);
        check("reset sda_oe", 32'(sda_oe), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'h00);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset tx_load", 32'(tx_load), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(5);

        for (int i = 0; i < 7; i++)
            run_txn(tbl[i].addr, tbl[i].n, tbl[i].data, tbl[i].exp_ack, $sformatf("vec%0d", i));

        // Partial write byte abandoned by a repeated START, then a read.
        rx0 = n_rx;
        tx0 = n_tx;
        bus_start();
        write_byte(8'h84, ack);
        check("rs addr_w_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) bus_bit(i[0], s);
        tx_data = 8'h96;
        bus_start();
        write_byte(8'h85, ack);
        check("rs addr_r_ack", 32'(ack), 32'd1);
        read_byte(1'b1, 8'h69, d);
        check("rs rd0", 32'(d), 32'h96);
        read_byte(1'b0, 8'h00, d);
        check("rs rd1", 32'(d), 32'h69);
        bus_stop();
        tick(4);
        check("rs rx_valid_count", 32'(n_rx - rx0), 32'd0);
        check("rs tx_load_count", 32'(n_tx - tx0), 32'd2);

        // STOP after five data bits: byte discarded, rx_data retained.
        rx0 = n_rx;
        bus_start();
        write_byte(8'h84, ack);
        check("partial addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 5; i++) bus_bit(~i[0], s);
        bus_stop();
        tick(4);
        check("partial rx_valid_count", 32'(n_rx - rx0), 32'd0);
        check("partial rx_data", 32'(rx_data), 32'(last_rx));
        check("partial busy", 32'(busy), 32'd0);

        // Randomised transactions against the address rule.
        for (int k = 0; k < 16; k++) begin
            logic [7:0]  a;
            int          n;
            logic [23:0] dat;
            a   = ($urandom_range(0, 2) != 0) ? {7'h42, 1'($urandom_range(0, 1))} : 8'($urandom);
            n   = $urandom_range(1, 3);
            dat = 24'($urandom);
            run_txn(a, n, dat, model_ack(a), $sformatf("rand%0d", k));
        end

        // Reset while the target drives a 0 data bit on a read.
        tx_data = 8'h00;
        bus_start();
        write_byte(8'h85, ack);
        check("rst_mid addr_ack", 32'(ack), 32'd1);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(5);
        check("rst_mid driving", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        tick(1);
        check("rst_mid sda_oe", 32'(sda_oe), 32'd0);
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid rx_data", 32'(rx_data), 32'h00);
        check("rst_mid rx_valid", 32'(rx_valid), 32'd0);
        check("rst_mid tx_load", 32'(tx_load), 32'd0);
        rst = 1'b0;
        last_rx = 8'h00;
        tick(Q);
        scl_m = 1'b0; tick(Q);
        bus_stop();
        tick(4);
        run_txn(8'h84, 1, 24'h00003E, 1'b1, "post_rst");

        check("pulse/oe rule violations", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
